mem_access_stage: RTL

Memory-access pipeline stage between EXE and WriteBack. It issues one SRAM-like data-bus transaction per load/store and builds byte strobes, store data and size. It resolves load sub-word selects from the address and holds returned read data in a stable register. WriteBack consumes that register as its `data_rdata`, with `data_data_ok` tied high, for as long as the load occupies WriteBack.

---
 rtl/mem_access_stage.sv | 335 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access pipeline stage sitting between EXE and WriteBack. Each load or
// store held in the stage issues exactly one SRAM-like data-bus transaction.
// The stage builds the bus size, byte strobes and store data, decodes the
// load sub-word select for WriteBack, and keeps returned read data in a stable
// register (MEM_rdata_o) that WriteBack consumes with data_data_ok tied high.
//
// Optional feature macro: MEM_LWLR_EN
//   defined   : full unaligned lwl/lwr/swl/swr decode.
//   undefined : lwl/lwr decode as lw, swl/swr decode as sw (aligned address,
//               all byte strobes, unshifted rt data).
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   EXE_*                    instruction payload and valid from EXE
//   WB_allowin_w_i           WriteBack can accept this cycle
//   WB_hasRisk_w_i           downstream exception risk, blocks new bus requests
//   MEM_allowin_w_o          stage can accept from EXE this cycle
//   MEM_valid_w_o            stage presents a finished instruction to WriteBack
//   MEM_hasRisk_w_o          held exception risk OR downstream risk
//   MEM_writeNum_w_o         held destination register, for ID forwarding
//   data_*                   SRAM-like data bus (req/addr_ok, data_ok/rdata)
//   MEM_*_o                  payload to WriteBack (memReq = load in flight)
//   MEM_alignCheck_o         low address bits of the access
//   MEM_loadSel_o            one-hot load sub-word select
//   MEM_rdata_o              read data held for WriteBack
//   state_dbg                current FSM state (IDLE/REQ/WAIT/HOLD = 0..3)
//
// Handshake: a transfer across a valid/ready pair happens on a rising clk edge
// where both sides are high (EXE_valid_w_i & MEM_allowin_w_o into this stage,
// MEM_valid_w_o & WB_allowin_w_i out of it; data_req & data_addr_ok for a bus
// request). A raised valid/req keeps its payload stable until it transfers.
// -----------------------------------------------------------------------------
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_valid_w_i,
  input  logic        WB_allowin_w_i,
  input  logic        WB_hasRisk_w_i,
  input  logic [4:0]  EXE_writeNum_i,
  input  logic        EXE_exceptionRisk_i,
  input  logic        EXE_isDangerous_i,
  input  logic [31:0] EXE_VAddr_i,
  input  logic [31:0] EXE_finalRes_i,
  input  logic [31:0] EXE_rtData_i,
  input  logic [31:0] EXE_memAddr_i,
  input  logic [2:0]  EXE_loadKind_i,
  input  logic [2:0]  EXE_storeKind_i,
  output logic        MEM_allowin_w_o,
  output logic        MEM_valid_w_o,
  output logic        MEM_hasRisk_w_o,
  output logic [4:0]  MEM_writeNum_w_o,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [4:0]  MEM_writeNum_o,
  output logic        MEM_exceptionRisk_o,
  output logic        MEM_memReq_o,
  output logic [31:0] MEM_VAddr_o,
  output logic        MEM_isDangerous_o,
  output logic [31:0] MEM_finalRes_o,
  output logic [31:0] MEM_rtData_o,
  output logic [1:0]  MEM_alignCheck_o,
  output logic [10:0] MEM_loadSel_o,
  output logic [31:0] MEM_rdata_o,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state, state_nxt;
  logic        has_data;
  logic [4:0]  write_num_q;
  logic        exc_risk_q;
  logic        is_dangerous_q;
  logic [31:0] vaddr_q;
  logic [31:0] final_res_q;
  logic [31:0] rt_data_q;
  logic [31:0] mem_addr_q;
  logic [2:0]  load_kind_q;
  logic [2:0]  store_kind_q;
  logic [31:0] hold_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        drain;
  logic        handover;
  logic        is_mem_in;

  logic [1:0]  a;
  logic [31:0] addr_aligned;
  logic [10:0] load_sel;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;

  assign accept    = EXE_valid_w_i && MEM_allowin_w_o;
  assign drain     = MEM_allowin_w_o && !EXE_valid_w_i;
  assign handover  = MEM_valid_w_o && WB_allowin_w_i;
  assign is_mem_in = (EXE_loadKind_i != 3'd0) || (EXE_storeKind_i != 3'd0);

  // The result is ready in IDLE (no bus work, or bus work skipped because of a
  // known exception), in the WAIT cycle where the response arrives, or in HOLD.
  assign MEM_valid_w_o   = has_data && ((state == S_IDLE) ||
                                        ((state == S_WAIT) && data_data_ok) ||
                                        (state == S_HOLD));
  assign MEM_allowin_w_o = !has_data || handover;

  // ---------------------------------------------------------------------------
  // Pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      has_data       <= 1'b0;
      write_num_q    <= 5'd0;
      exc_risk_q     <= 1'b0;
      is_dangerous_q <= 1'b0;
      vaddr_q        <= 32'd0;
      final_res_q    <= 32'd0;
      rt_data_q      <= 32'd0;
      mem_addr_q     <= 32'd0;
      load_kind_q    <= 3'd0;
      store_kind_q   <= 3'd0;
    end else if (accept) begin
      has_data       <= 1'b1;
      write_num_q    <= EXE_writeNum_i;
      exc_risk_q     <= EXE_exceptionRisk_i;
      is_dangerous_q <= EXE_isDangerous_i;
      vaddr_q        <= EXE_VAddr_i;
      final_res_q    <= EXE_finalRes_i;
      rt_data_q      <= EXE_rtData_i;
      mem_addr_q     <= EXE_memAddr_i;
      load_kind_q    <= EXE_loadKind_i;
      store_kind_q   <= EXE_storeKind_i;
    end else if (drain) begin
      has_data       <= 1'b0;
      write_num_q    <= 5'd0;
      exc_risk_q     <= 1'b0;
      is_dangerous_q <= 1'b0;
      vaddr_q        <= 32'd0;
      final_res_q    <= 32'd0;
      rt_data_q      <= 32'd0;
      mem_addr_q     <= 32'd0;
      load_kind_q    <= 3'd0;
      store_kind_q   <= 3'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus FSM. Whenever the stage opens up (allowin), the incoming instruction
  // decides the next state; otherwise the current transaction advances.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = (is_mem_in && !EXE_exceptionRisk_i) ? S_REQ : S_IDLE;
    end else if (drain) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_REQ:   if (data_req && data_addr_ok) state_nxt = S_WAIT;
        S_WAIT:  if (data_data_ok) state_nxt = handover ? S_IDLE : S_HOLD;
        S_HOLD:  if (handover) state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Response arrived but WriteBack is stalled: park it until handover, since
  // the slave only drives data_rdata for the single data_data_ok cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= 32'd0;
    end else if ((state == S_WAIT) && data_data_ok && !handover) begin
      hold_q <= data_rdata;
    end
  end

  // WriteBack reads MEM_rdata_o after handover, so it only changes when a
  // load that actually went to the bus hands over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'd0;
    end else if (handover && (load_kind_q != 3'd0)) begin
      if (state == S_WAIT) begin
        rdata_q <= data_rdata;
      end else if (state == S_HOLD) begin
        rdata_q <= hold_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Access decode from the held payload; stable while the request is pending.
  // ---------------------------------------------------------------------------
  assign a            = mem_addr_q[1:0];
  assign addr_aligned = {mem_addr_q[31:2], 2'b00};

  always_comb begin
    load_sel  = 11'd0;
    bus_size  = 2'd0;
    bus_addr  = mem_addr_q;
    bus_wstrb = 4'b0000;
    bus_wdata = 32'd0;
    case (load_kind_q)
      3'd1: begin load_sel[0] = 1'b1; bus_size = 2'd0; end
      3'd2: begin load_sel[1] = 1'b1; bus_size = 2'd0; end
      3'd3: begin load_sel[2] = 1'b1; bus_size = 2'd1; end
      3'd4: begin load_sel[3] = 1'b1; bus_size = 2'd1; end
      3'd5: begin load_sel[4] = 1'b1; bus_size = 2'd2; end
`ifdef MEM_LWLR_EN
      3'd6: begin
        bus_size = 2'd2;
        bus_addr = addr_aligned;
        case (a)
          2'd0:    load_sel[5] = 1'b1;
          2'd1:    load_sel[6] = 1'b1;
          2'd2:    load_sel[7] = 1'b1;
          default: load_sel[4] = 1'b1;  // lwl at offset 3 is a full word
        endcase
      end
      3'd7: begin
        bus_size = 2'd2;
        bus_addr = addr_aligned;
        case (a)
          2'd0:    load_sel[4] = 1'b1;  // lwr at offset 0 is a full word
          2'd1:    load_sel[8] = 1'b1;
          2'd2:    load_sel[9] = 1'b1;
          default: load_sel[10] = 1'b1;
        endcase
      end
`else
      3'd6, 3'd7: begin
        load_sel[4] = 1'b1;
        bus_size    = 2'd2;
        bus_addr    = addr_aligned;
      end
`endif
      default: ;
    endcase

    case (store_kind_q)
      3'd1: begin
        bus_size  = 2'd0;
        bus_wstrb = 4'b0001 << a;
        bus_wdata = {4{rt_data_q[7:0]}};
      end
      3'd2: begin
        bus_size  = 2'd1;
        bus_wstrb = a[1] ? 4'b1100 : 4'b0011;
        bus_wdata = {2{rt_data_q[15:0]}};
      end
      3'd3: begin
        bus_size  = 2'd2;
        bus_wstrb = 4'b1111;
        bus_wdata = rt_data_q;
      end
`ifdef MEM_LWLR_EN
      3'd4: begin
        bus_size = 2'd2;
        bus_addr = addr_aligned;
        case (a)
          2'd0:    begin bus_wstrb = 4'b0001; bus_wdata = rt_data_q >> 24; end
          2'd1:    begin bus_wstrb = 4'b0011; bus_wdata = rt_data_q >> 16; end
          2'd2:    begin bus_wstrb = 4'b0111; bus_wdata = rt_data_q >> 8;  end
          default: begin bus_wstrb = 4'b1111; bus_wdata = rt_data_q;       end
        endcase
      end
      3'd5: begin
        bus_size = 2'd2;
        bus_addr = addr_aligned;
        case (a)
          2'd0:    begin bus_wstrb = 4'b1111; bus_wdata = rt_data_q;       end
          2'd1:    begin bus_wstrb = 4'b1110; bus_wdata = rt_data_q << 8;  end
          2'd2:    begin bus_wstrb = 4'b1100; bus_wdata = rt_data_q << 16; end
          default: begin bus_wstrb = 4'b1000; bus_wdata = rt_data_q << 24; end
        endcase
      end
`else
      3'd4, 3'd5: begin
        bus_size  = 2'd2;
        bus_addr  = addr_aligned;
        bus_wstrb = 4'b1111;
        bus_wdata = rt_data_q;
      end
`endif
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data_req   = (state == S_REQ) && !WB_hasRisk_w_i;
  assign data_wr    = (store_kind_q != 3'd0);
  assign data_size  = bus_size;
  assign data_addr  = bus_addr;
  assign data_wdata = bus_wdata;
  assign data_wstrb = bus_wstrb;

  assign MEM_hasRisk_w_o     = exc_risk_q | WB_hasRisk_w_i;
  assign MEM_writeNum_w_o    = write_num_q;
  assign MEM_writeNum_o      = write_num_q;
  assign MEM_exceptionRisk_o = exc_risk_q;
  assign MEM_memReq_o        = (load_kind_q != 3'd0);
  assign MEM_VAddr_o         = vaddr_q;
  assign MEM_isDangerous_o   = is_dangerous_q;
  assign MEM_finalRes_o      = final_res_q;
  assign MEM_rtData_o        = rt_data_q;
  assign MEM_alignCheck_o    = a;
  assign MEM_loadSel_o       = load_sel;
  assign MEM_rdata_o         = rdata_q;
  assign state_dbg           = state;

endmodule
